led_breathe: RTL and testbench

LED_BREATHE -- requirements
Module: led_breathe

---
 rtl/led_breathe.sv | 274 +++++++++++++++++++++++++++
 tb/tb_led_breathe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/led_breathe.sv
// ---------------------------------------------------------------------------
// led_breathe -- two-channel PWM "breathing" LED driver.
//
// A free-running PWM counter compares against a duty value that ramps
// linearly 0 -> MAX, holds, ramps MAX -> 0, holds, and repeats for as long as
// enable is high. LED1 is driven at the duty, LED2 at the complementary duty
// (MAX - duty), so the two LEDs cross-fade. One breath ends when the FSM
// first enters HOLD_LO, which is marked by a single-cycle cycle_done pulse.
//
// Parameters
//   CLK_HZ      : CLKOS frequency in Hz (informational, sanity-checked only)
//   PWM_BITS    : PWM counter / duty width, MAX = 2^PWM_BITS - 1
//   STEP_CYCLES : CLKOS cycles per duty step (>= 1)
//   HOLD_STEPS  : step ticks spent in each hold state (>= 1)
//
// Ports
//   CLKOS      in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   enable     in   1 = run the breathing sequence, 0 = LEDs off
//   LED1       out  registered PWM output at eff
//   LED2       out  registered PWM output at MAX - eff
//   duty       out  current linear duty value
//   state      out  OFF=0, RAMP_UP=1, HOLD_HI=2, RAMP_DOWN=3, HOLD_LO=4
//   cycle_done out  one-cycle pulse when a breath completes
//
// Build option
//   LED_GAMMA_EN : when defined, the PWM compare uses a squared (gamma-like)
//                  brightness eff = (duty*duty) >> PWM_BITS instead of duty.
//                  The LED latency is the same in both builds.
// ---------------------------------------------------------------------------
module led_breathe #(
  parameter int CLK_HZ      = 78_000_000,
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 38_000,
  parameter int HOLD_STEPS  = 64
) (
  input  logic                CLKOS,
  input  logic                Reset_n,
  input  logic                enable,
  output logic                LED1,
  output logic                LED2,
  output logic [PWM_BITS-1:0] duty,
  output logic [2:0]          state,
  output logic                cycle_done
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // -------------------------------------------------------------------------
  if (CLK_HZ <= 0) begin : g_bad_clk_hz
    $error("led_breathe: CLK_HZ must be positive");
  end
  if (PWM_BITS < 1) begin : g_bad_pwm_bits
    $error("led_breathe: PWM_BITS must be at least 1");
  end
  if (STEP_CYCLES < 1) begin : g_bad_step_cycles
    $error("led_breathe: STEP_CYCLES must be at least 1");
  end
  if (HOLD_STEPS < 1) begin : g_bad_hold_steps
    $error("led_breathe: HOLD_STEPS must be at least 1");
  end

  // -------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------
  // Counter widths are kept at least one bit wide so STEP_CYCLES=1 and
  // HOLD_STEPS=1 still produce legal vectors (the counter then sits at 0).
  localparam int PRE_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_STEPS  > 1) ? $clog2(HOLD_STEPS)  : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(STEP_CYCLES - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
  localparam logic [PWM_BITS-1:0] MAX_DUTY  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] ONE_DUTY  = PWM_BITS'(1);

  // FSM encoding is fixed because it is visible on the state port.
  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_RAMP_UP   = 3'd1;
  localparam logic [2:0] ST_HOLD_HI   = 3'd2;
  localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
  localparam logic [2:0] ST_HOLD_LO   = 3'd4;

  // -------------------------------------------------------------------------
  // Internal signals
  // -------------------------------------------------------------------------
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [PRE_W-1:0]    presc_r;
  logic [HOLD_W-1:0]   hold_cnt_r;

  logic                tick_s;
  logic [PWM_BITS-1:0] eff_s;
  logic [PWM_BITS-1:0] eff_inv_s;

  logic [2:0]          state_nxt_s;
  logic [PWM_BITS-1:0] duty_nxt_s;
  logic [HOLD_W-1:0]   hold_nxt_s;
  logic                done_nxt_s;

`ifdef LED_GAMMA_EN
  // Squared brightness: the full 2*PWM_BITS product is formed before the
  // shift so no high-order bits are lost, then the upper half is kept.
  function automatic logic [PWM_BITS-1:0] gamma_eff(input logic [PWM_BITS-1:0] d);
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
    return sq[2*PWM_BITS-1:PWM_BITS];
  endfunction
`endif

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------

  // Effective brightness used by the PWM comparators.
  always_comb begin
`ifdef LED_GAMMA_EN
    eff_s = gamma_eff(duty);
`else
    eff_s = duty;
`endif
    eff_inv_s = MAX_DUTY - eff_s;
  end

  // Step tick: one cycle in every STEP_CYCLES while enabled.
  always_comb begin
    tick_s = enable && (presc_r == PRE_LAST);
  end

  // Free-running PWM counter; wraps naturally at MAX.
  always_ff @(posedge CLKOS or negedge Reset_n) begin
    if (!Reset_n) begin
      pwm_cnt_r <= '0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + ONE_DUTY;
    end
  end

  // Step prescaler; held at 0 while disabled so a new run starts a full step.
  always_ff @(posedge CLKOS or negedge Reset_n) begin
    if (!Reset_n) begin
      presc_r <= '0;
    end else if (!enable) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRE_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Breathing FSM
  // -------------------------------------------------------------------------

  // Next-state / next-duty logic. A low enable overrides everything,
  // including a tick arriving in the same cycle.
  always_comb begin
    state_nxt_s = state;
    duty_nxt_s  = duty;
    hold_nxt_s  = hold_cnt_r;
    done_nxt_s  = 1'b0;

    if (!enable) begin
      state_nxt_s = ST_OFF;
      duty_nxt_s  = '0;
      hold_nxt_s  = '0;
    end else begin
      case (state)
        ST_OFF: begin
          state_nxt_s = ST_RAMP_UP;
          duty_nxt_s  = '0;
          hold_nxt_s  = '0;
        end

        ST_RAMP_UP: begin
          if (tick_s) begin
            // '>=' rather than '==' so a corrupted duty can never wrap past MAX.
            if (duty >= (MAX_DUTY - ONE_DUTY)) begin
              duty_nxt_s  = MAX_DUTY;
              state_nxt_s = ST_HOLD_HI;
              hold_nxt_s  = '0;
            end else begin
              duty_nxt_s = duty + ONE_DUTY;
            end
          end else begin
            duty_nxt_s = duty;
          end
        end

        ST_HOLD_HI: begin
          if (tick_s) begin
            if (hold_cnt_r >= HOLD_LAST) begin
              state_nxt_s = ST_RAMP_DOWN;
              hold_nxt_s  = '0;
            end else begin
              hold_nxt_s = hold_cnt_r + HOLD_W'(1);
            end
          end else begin
            hold_nxt_s = hold_cnt_r;
          end
        end

        ST_RAMP_DOWN: begin
          if (tick_s) begin
            // '<=' guards against wrapping below zero.
            if (duty <= ONE_DUTY) begin
              duty_nxt_s  = '0;
              state_nxt_s = ST_HOLD_LO;
              hold_nxt_s  = '0;
              done_nxt_s  = 1'b1;
            end else begin
              duty_nxt_s = duty - ONE_DUTY;
            end
          end else begin
            duty_nxt_s = duty;
          end
        end

        ST_HOLD_LO: begin
          if (tick_s) begin
            if (hold_cnt_r >= HOLD_LAST) begin
              state_nxt_s = ST_RAMP_UP;
              hold_nxt_s  = '0;
            end else begin
              hold_nxt_s = hold_cnt_r + HOLD_W'(1);
            end
          end else begin
            hold_nxt_s = hold_cnt_r;
          end
        end

        default: begin
          // Unreachable encodings recover to OFF.
          state_nxt_s = ST_OFF;
          duty_nxt_s  = '0;
          hold_nxt_s  = '0;
        end
      endcase
    end
  end

  // FSM state, duty, hold counter and breath-complete pulse registers.
  always_ff @(posedge CLKOS or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ST_OFF;
      duty       <= '0;
      hold_cnt_r <= '0;
      cycle_done <= 1'b0;
    end else begin
      state      <= state_nxt_s;
      duty       <= duty_nxt_s;
      hold_cnt_r <= hold_nxt_s;
      cycle_done <= done_nxt_s;
    end
  end

  // -------------------------------------------------------------------------
  // LED outputs
  // -------------------------------------------------------------------------

  // Registered PWM comparators; forced dark on the edge after enable drops.
  always_ff @(posedge CLKOS or negedge Reset_n) begin
    if (!Reset_n) begin
      LED1 <= 1'b0;
      LED2 <= 1'b0;
    end else if (!enable) begin
      LED1 <= 1'b0;
      LED2 <= 1'b0;
    end else begin
      LED1 <= (pwm_cnt_r < eff_s);
      LED2 <= (pwm_cnt_r < eff_inv_s);
    end
  end

endmodule

// File: tb/tb_led_breathe.sv
// ---------------------------------------------------------------------------
// tb_led_breathe -- self-checking bench for led_breathe
// (PWM_BITS=4, STEP_CYCLES=2, HOLD_STEPS=2, linear duty).
//
// The reference model derives the expected FSM state and duty purely from the
// number of enabled clock edges since enable rose: k = edges / STEP_CYCLES
// ticks have elapsed, and k modulo the breath period picks the segment
// (ramp up, hold high, ramp down, hold low) by plain arithmetic. LED
// expectations come from the modelled PWM count and the previous duty.
// ---------------------------------------------------------------------------
module tb_led_breathe;

  localparam int PWM_BITS = 4;
  localparam int STEP     = 2;
  localparam int HOLD     = 2;
  localparam int MAXV     = (1 << PWM_BITS) - 1;
  localparam int PER      = 2 * MAXV + 2 * HOLD;

  logic                CLKOS = 1'b0;
  logic                Reset_n;
  logic                enable;
  logic                LED1;
  logic                LED2;
  logic [PWM_BITS-1:0] duty;
  logic [2:0]          state;
  logic                cycle_done;

  led_breathe #(
    .CLK_HZ     (1_000_000),
    .PWM_BITS   (PWM_BITS),
    .STEP_CYCLES(STEP),
    .HOLD_STEPS (HOLD)
  ) dut (
    .CLKOS     (CLKOS),
    .Reset_n   (Reset_n),
    .enable    (enable),
    .LED1      (LED1),
    .LED2      (LED2),
    .duty      (duty),
    .state     (state),
    .cycle_done(cycle_done)
  );

  always #5 CLKOS = ~CLKOS;

  int n_checks = 0;
  int n_err    = 0;

  // model state
  int m_pwm;   // PWM count the DUT should hold now
  int m_n;     // enabled edges since enable rose (0 = OFF)
  int m_duty;  // duty the DUT should show now
  int cyc;

  typedef struct {
    logic en;
    int   cycles;
    int   st;
    int   du;
    int   done;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expected state/duty/cycle_done after n enabled edges.
  function automatic void ref_model(input int n, output int st, output int du, output int dn);
    int k, p;
    st = 0; du = 0; dn = 0;
    if (n > 0) begin
      k = n / STEP;
      p = k % PER;
      if (p < MAXV) begin
        st = 1; du = p;
      end else if (p < MAXV + HOLD) begin
        st = 2; du = MAXV;
      end else if (p < 2 * MAXV + HOLD) begin
        st = 3; du = MAXV - (p - MAXV - HOLD);
      end else begin
        st = 4; du = 0;
      end
      dn = ((n % STEP) == 0 && p == 2 * MAXV + HOLD) ? 1 : 0;
    end
  endfunction

  // One clock: drive enable at the falling edge, advance model, check at next falling edge.
  task automatic do_cycle(input logic en);
    int pwm_b, duty_b, st, du, dn, l1, l2;
    enable = en;
    @(posedge CLKOS);
    pwm_b  = m_pwm;
    duty_b = m_duty;
    m_pwm  = (m_pwm + 1) % (MAXV + 1);
    m_n    = en ? m_n + 1 : 0;
    ref_model(m_n, st, du, dn);
    m_duty = du;
    l1 = (en && pwm_b < duty_b) ? 1 : 0;
    l2 = (en && pwm_b < MAXV - duty_b) ? 1 : 0;
    cyc++;
    @(negedge CLKOS);
    check("state", 32'(state), st);
    check("duty", 32'(duty), du);
    check("cycle_done", 32'(cycle_done), dn);
    check("LED1", 32'(LED1), l1);
    check("LED2", 32'(LED2), l2);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before the next rising edge.
  task automatic apply_reset();
    #2;
    Reset_n = 1'b0;
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_duty", 32'(duty), 0);
    check("rst_LED1", 32'(LED1), 0);
    check("rst_LED2", 32'(LED2), 0);
    check("rst_done", 32'(cycle_done), 0);
    @(negedge CLKOS);
    Reset_n = 1'b1;
    m_pwm = 0; m_n = 0; m_duty = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic en_r;

    vecs[0]  = '{1'b0, 100, 0,  0, 0};
    vecs[1]  = '{1'b1,   1, 1,  0, 0};
    vecs[2]  = '{1'b1,  28, 1, 14, 0};
    vecs[3]  = '{1'b1,   1, 2, 15, 0};
    vecs[4]  = '{1'b1,   3, 2, 15, 0};
    vecs[5]  = '{1'b1,   1, 3, 15, 0};
    vecs[6]  = '{1'b1,  29, 3,  1, 0};
    vecs[7]  = '{1'b1,   1, 4,  0, 1};
    vecs[8]  = '{1'b1,   1, 4,  0, 0};
    vecs[9]  = '{1'b1,   3, 1,  0, 0};
    vecs[10] = '{1'b1,   2, 1,  1, 0};
    vecs[11] = '{1'b1,  13, 1,  7, 0};
    vecs[12] = '{1'b0,   1, 0,  0, 0};
    vecs[13] = '{1'b1,   1, 1,  0, 0};
    vecs[14] = '{1'b1,   1, 1,  1, 0};

    cyc = 0;
    Reset_n = 1'b0;
    enable  = 1'b0;
    #3;
    check("init_state", 32'(state), 0);
    check("init_duty", 32'(duty), 0);
    check("init_LED1", 32'(LED1), 0);
    check("init_LED2", 32'(LED2), 0);
    check("init_done", 32'(cycle_done), 0);
    @(negedge CLKOS);
    Reset_n = 1'b1;
    m_pwm = 0; m_n = 0; m_duty = 0;

    // Directed milestones: idle, full ramp up, holds, ramp down, drop on tick.
    for (int v = 0; v < 15; v++) begin
      for (int c = 0; c < vecs[v].cycles; c++) do_cycle(vecs[v].en);
      check($sformatf("vec%0d_state", v), 32'(state), vecs[v].st);
      check($sformatf("vec%0d_duty", v), 32'(duty), vecs[v].du);
      check($sformatf("vec%0d_done", v), 32'(cycle_done), vecs[v].done);
    end

    // Reset asserted mid RAMP_DOWN, then restart through OFF.
    for (int i = 0; i < 200 && state != 3'd3; i++) do_cycle(1'b1);
    check("reach_ramp_down", 32'(state), 3);
    for (int i = 0; i < 5; i++) do_cycle(1'b1);
    apply_reset();
    do_cycle(1'b1);
    check("restart_state", 32'(state), 1);
    check("restart_duty", 32'(duty), 0);

    // Randomized enable toggling with occasional resets.
    en_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (en_r) begin
        if ($urandom_range(0, 39) == 0) en_r = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) en_r = 1'b1;
      end
      if ($urandom_range(0, 399) == 0) apply_reset();
      else do_cycle(en_r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
